// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one 8-bit divider among NUM_REQ requesters.
// Divide-by-zero is answered locally; a hung divider is aborted after TIMEOUT cycles in WAIT.
//
// state | meaning
// IDLE  | scan ReqVec from ptr, grant and latch operands
// ISSUE | DivReq pulse with latched operands, arm timeout counter
// WAIT  | wait for DivDone or timeout
// RESP  | Ack/result pulse to owner, advance round-robin pointer
module divider_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic [NUM_REQ-1:0]         ReqVec,
  input  logic [8*NUM_REQ-1:0]       Op1Bus,
  input  logic [8*NUM_REQ-1:0]       Op2Bus,
  output logic [NUM_REQ-1:0]         AckVec,
  output logic [7:0]                 QuotientOut,
  output logic [7:0]                 RemainderOut,
  output logic                       DivZero,
  output logic                       Error,
  output logic [$clog2(NUM_REQ)-1:0] GrantId,
  output logic                       Busy,
  output logic                       DivReq,
  output logic [7:0]                 DivOperand1,
  output logic [7:0]                 DivOperand2,
  input  logic                       DivDone,
  input  logic [7:0]                 DivQuotient,
  input  logic [7:0]                 DivRemainder
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick;
  logic [IW-1:0] next_ptr;
  logic [TW-1:0] timer;
  logic [7:0]    pick_op1;
  logic [7:0]    pick_op2;
  int            idx;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  // Scan from the far end back toward ptr so the closest requester is written last.
  always_comb begin
    pick = ptr;
    idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (ReqVec[IW'(idx)]) pick = IW'(idx);
    end
  end

  always_comb begin
    pick_op1 = '0;
    pick_op2 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IW'(k) == pick) begin
        pick_op1 = Op1Bus[8*k +: 8];
        pick_op2 = Op2Bus[8*k +: 8];
      end
    end
  end

  assign next_ptr = (int'(GrantId) == NUM_REQ - 1) ? '0 : GrantId + 1'b1;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      ptr          <= '0;
      timer        <= '0;
      GrantId      <= '0;
      AckVec       <= '0;
      QuotientOut  <= '0;
      RemainderOut <= '0;
      DivZero      <= 1'b0;
      Error        <= 1'b0;
      Busy         <= 1'b0;
      DivReq       <= 1'b0;
      DivOperand1  <= '0;
      DivOperand2  <= '0;
    end else begin
      // result outputs are single-cycle pulses
      AckVec       <= '0;
      QuotientOut  <= '0;
      RemainderOut <= '0;
      DivZero      <= 1'b0;
      Error        <= 1'b0;
      DivReq       <= 1'b0;
      case (state)
        IDLE: begin
          if (|ReqVec) begin
            GrantId     <= pick;
            DivOperand1 <= pick_op1;
            DivOperand2 <= pick_op2;
            Busy        <= 1'b1;
            if (pick_op2 == 8'h00) begin
              state        <= RESP;
              AckVec       <= onehot(pick);
              DivZero      <= 1'b1;
              QuotientOut  <= 8'hFF;
              RemainderOut <= pick_op1;
            end else begin
              state  <= ISSUE;
              DivReq <= 1'b1;
            end
          end
        end
        ISSUE: begin
          timer <= TW'(TIMEOUT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (DivDone) begin
            state        <= RESP;
            AckVec       <= onehot(GrantId);
            QuotientOut  <= DivQuotient;
            RemainderOut <= DivRemainder;
          end else if (timer == '0) begin
            state        <= RESP;
            AckVec       <= onehot(GrantId);
            Error        <= 1'b1;
            QuotientOut  <= 8'hFF;
            RemainderOut <= 8'h00;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RESP: begin
          Busy  <= 1'b0;
          ptr   <= next_ptr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
